banco_registradores_param: RTL and testbench

//  Parametrised successor of the 32x64 integer register bank for the RISC-V datapath.

---
 rtl/banco_registradores_param_pkg.sv | 19 +
 rtl/banco_registradores_param_placar.sv | 46 ++++
 rtl/banco_registradores_param.sv | 89 ++++++++
 tb/tb_banco_registradores_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_param_pkg.sv
// Shared types and helpers for the parametrised integer register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package banco_pkg;

  localparam int unsigned DEF_BITS  = 64;
  localparam int unsigned DEF_NREGS = 32;

  typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;
  typedef logic [DEF_BITS-1:0]          reg_data_t;

  localparam reg_data_t REG_ZERO = '0;

  // An address names real storage only if it is not x0 and lies inside the bank.
  function automatic logic ADDR_VALID(input int unsigned addr, input int unsigned nregs);
    return (addr != 0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/banco_registradores_param_placar.sv
// Busy scoreboard: one bit per register, set by decode reservation, cleared by writeback.
// Latency: set/clear take effect on the edge; busy visible the following cycle.
// Backpressure: none; a set and a clear can arrive every cycle, set wins on collision.
module placar_reservas
  import banco_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: x0 never busy, out-of-range addresses match no entry.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < int'(NREGS); r++) begin
      if (set_en_i && (set_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (clr_en_i && (clr_addr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register with synchronous reset overriding set/clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank with x0 hardwired to zero, NRD read ports, optional write->read bypass and busy scoreboard.
// Latency: reads combinational; write visible same cycle (bypass) or next cycle; reservation visible next cycle.
// Backpressure: none; one write, one reservation and NRD reads accepted every cycle.
module banco_registradores_param
  import banco_pkg::*;
#(
  parameter int unsigned BITS   = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter bit          BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*BITS-1:0] dout,
  output logic [NRD-1:0]      rd_busy,
  input  logic                We,
  input  logic [AW-1:0]       Rw,
  input  logic [BITS-1:0]     din,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy
);

  logic [BITS-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy_vec;

  // Entry 0 is a constant, never stored.
  assign rf[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    logic [BITS-1:0] reg_q;

    // Write-enabled storage flop for register g.
    always_ff @(posedge clk) begin
      if (reset) begin
        reg_q <= '0;
      end else if (We && (Rw == AW'(g))) begin
        reg_q <= din;
      end
    end

    assign rf[g] = reg_q;
  end

  placar_reservas #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_placar (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (rsv_en),
    .set_addr_i (rsv_addr),
    .clr_en_i   (We),
    .clr_addr_i (Rw),
    .busy_o     (busy_vec)
  );

  assign busy = busy_vec;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic            byp_hit;
    logic [BITS-1:0] rd_dat;
    logic            rd_bsy;

    assign rd_addr = ra[i*AW +: AW];
    assign byp_hit = BYPASS && We && (Rw == rd_addr) && (Rw != '0);

    // Read mux: invalid address reads zero/not-busy; bypassed write hides the pending reservation.
    always_comb begin
      rd_dat = '0;
      rd_bsy = 1'b0;
      if (ADDR_VALID(32'(rd_addr), NREGS)) begin
        if (byp_hit) begin
          rd_dat = din;
        end else begin
          rd_dat = rf[rd_addr];
          rd_bsy = busy_vec[rd_addr];
        end
      end
    end

    assign dout[i*BITS +: BITS] = rd_dat;
    assign rd_busy[i]           = rd_bsy;
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Self-checking bench: two banks (bypass on/off) share stimulus and are compared against an array model.
module tb_banco_registradores_param;

  localparam int BITS  = 64;
  localparam int NREGS = 24;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NRD*AW-1:0]   ra;
  logic                We;
  logic [AW-1:0]       Rw;
  logic [BITS-1:0]     din;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;

  logic [NRD*BITS-1:0] dout_b, dout_n;
  logic [NRD-1:0]      rdb_b, rdb_n;
  logic [NREGS-1:0]    busy_b, busy_n;

  banco_registradores_param #(.BITS(BITS), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .ra(ra), .dout(dout_b), .rd_busy(rdb_b),
    .We(We), .Rw(Rw), .din(din), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_b)
  );

  banco_registradores_param #(.BITS(BITS), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .reset(reset), .ra(ra), .dout(dout_n), .rd_busy(rdb_n),
    .We(We), .Rw(Rw), .din(din), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_n)
  );

  // Reference model: register contents and reservation flags.
  logic [BITS-1:0] m_mem [NREGS];
  bit              m_bsy [NREGS];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_bank(input int a);
    return (a != 0) && (a < NREGS);
  endfunction

  function automatic logic [BITS-1:0] exp_dout(input int i, input bit byp);
    int a;
    a = int'(ra[i*AW +: AW]);
    if (!in_bank(a)) return '0;
    if (byp && We && int'(Rw) == a) return din;
    return m_mem[a];
  endfunction

  function automatic logic exp_rdb(input int i, input bit byp);
    int a;
    a = int'(ra[i*AW +: AW]);
    if (!in_bank(a)) return 1'b0;
    if (byp && We && int'(Rw) == a) return 1'b0;
    return m_bsy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_busy();
    logic [NREGS-1:0] v;
    v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_bsy[r];
    return v;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("%s dout%0d byp", tag, i), dout_b[i*BITS +: BITS], exp_dout(i, 1'b1));
      chk($sformatf("%s dout%0d nob", tag, i), dout_n[i*BITS +: BITS], exp_dout(i, 1'b0));
      chk($sformatf("%s rd_busy%0d byp", tag, i), 64'(rdb_b[i]), 64'(exp_rdb(i, 1'b1)));
      chk($sformatf("%s rd_busy%0d nob", tag, i), 64'(rdb_n[i]), 64'(exp_rdb(i, 1'b0)));
    end
    chk($sformatf("%s busy byp", tag), 64'(busy_b), 64'(exp_busy()));
    chk($sformatf("%s busy nob", tag), 64'(busy_n), 64'(exp_busy()));
  endtask

  // Apply the clock-edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    int w, s;
    w = int'(Rw);
    s = int'(rsv_addr);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r] = '0;
        m_bsy[r] = 1'b0;
      end
    end else begin
      if (We && in_bank(w)) begin
        m_mem[w] = din;
        m_bsy[w] = 1'b0;
      end
      if (rsv_en && in_bank(s)) m_bsy[s] = 1'b1;
    end
  endtask

  task automatic tick(input string tag);
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic idle();
    reset = 1'b0; We = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    // Reset with a competing write: reset must win.
    reset = 1'b1; We = 1'b1; Rw = 5'd5; din = 64'hAA;
    rsv_en = 1'b1; rsv_addr = 5'd5; set_ra(5'd5, 5'd5, 5'd5);
    @(posedge clk);
    model_edge();
    #1;
    idle();
    #1;
    chk("reset dout0", dout_b[0 +: BITS], 64'h0);
    chk("reset busy", 64'(busy_b), 64'h0);
    chk("reset rd_busy", 64'(rdb_b), 64'h0);
    tick("reset");

    // Write to r3 read on port 0 in the same cycle.
    We = 1'b1; Rw = 5'd3; din = 64'h1234; set_ra(5'd3, 5'd0, 5'd0);
    #1;
    chk("bypass same cycle", dout_b[0 +: BITS], 64'h1234);
    chk("no-bypass same cycle", dout_n[0 +: BITS], 64'h0);
    tick("wr3");
    idle();
    #1;
    chk("no-bypass next cycle", dout_n[0 +: BITS], 64'h1234);

    // x0 writes and reservations are ignored.
    We = 1'b1; Rw = 5'd0; din = 64'hFFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
    set_ra(5'd0, 5'd0, 5'd3);
    #1;
    chk("x0 read during write", dout_b[0 +: BITS], 64'h0);
    tick("x0");
    idle();
    #1;
    chk("x0 read after write", dout_b[0 +: BITS], 64'h0);
    chk("x0 never busy", 64'(busy_b[0]), 64'h0);

    // Reserve r7, then release it through a write.
    rsv_en = 1'b1; rsv_addr = 5'd7; set_ra(5'd0, 5'd7, 5'd0);
    #1;
    chk("rsv not yet visible", 64'(rdb_b[1]), 64'h0);
    tick("rsv7");
    idle();
    #1;
    chk("busy7 set", 64'(busy_b[7]), 64'h1);
    chk("rd_busy1 set", 64'(rdb_b[1]), 64'h1);
    We = 1'b1; Rw = 5'd7; din = 64'h77;
    #1;
    chk("release bypass rd_busy", 64'(rdb_b[1]), 64'h0);
    chk("release no-bypass rd_busy", 64'(rdb_n[1]), 64'h1);
    tick("rel7");
    idle();
    #1;
    chk("busy7 cleared", 64'(busy_b[7]), 64'h0);

    // Collision: reserve and write-back of r9 in one cycle keeps it busy.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick("rsv9");
    We = 1'b1; Rw = 5'd9; din = 64'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
    tick("col9");
    idle(); set_ra(5'd9, 5'd0, 5'd0);
    #1;
    chk("collision busy9", 64'(busy_n[9]), 64'h1);
    chk("collision data9", dout_n[0 +: BITS], 64'h99);

    // Out-of-range addressing on the 24-entry bank.
    We = 1'b1; Rw = 5'd2; din = 64'h55;
    tick("wr2");
    idle(); set_ra(5'd2, 5'd2, 5'd30);
    #1;
    chk("dup read p0", dout_n[0 +: BITS], 64'h55);
    chk("dup read p1", dout_n[BITS +: BITS], 64'h55);
    chk("oob read p2", dout_n[2*BITS +: BITS], 64'h0);
    We = 1'b1; Rw = 5'd30; din = 64'hDEAD; rsv_en = 1'b1; rsv_addr = 5'd30;
    tick("wr30");
    idle();
    #1;
    chk("oob write ignored", dout_n[2*BITS +: BITS], 64'h0);
    tick("post30");

    // Randomized traffic including occasional resets and out-of-range addresses.
    for (int c = 0; c < 500; c++) begin
      reset    = ($urandom_range(0, 39) == 0);
      We       = $urandom_range(0, 1);
      Rw       = AW'($urandom_range(0, 31));
      din      = {$urandom, $urandom};
      rsv_en   = $urandom_range(0, 1);
      rsv_addr = AW'($urandom_range(0, 31));
      set_ra(AW'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0) ? Rw : AW'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0) ? rsv_addr : AW'($urandom_range(0, 31)));
      #1;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
